alu_cmd_issuer: RTL and testbench

Initiator-side front end for the synchronous 16-bit ALU (`ALU_sync`). It accepts operation requests over a valid/ready handshake and drives the ALU operand and function inputs. It waits out the ALU register latency, then captures the ALU result and class flags and returns them over a valid/ready response channel. It checks flag consistency and rejects illegal operations, so upstream logic (sequencer, register file) never talks to the ALU pins directly.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_flag_check.sv | 38 +++
 rtl/alu_cmd_issuer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_issuer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, function classes and the classifier shared by the ALU
// command issuer and its flag checker.
//   ALU_*      : 4-bit function codes understood by ALU_sync
//   fun_class_e: class of a function code (ILLEGAL for ALU_NOP)
//   fun_class(): maps a function code onto its class
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NAND = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_XNOR = 4'b1001;
  localparam logic [3:0] ALU_EQ   = 4'b1010;
  localparam logic [3:0] ALU_GT   = 4'b1011;
  localparam logic [3:0] ALU_LT   = 4'b1100;
  localparam logic [3:0] ALU_SHR  = 4'b1101;
  localparam logic [3:0] ALU_SHL  = 4'b1110;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [2:0] {ARITH, LOGIC, CMP, SHIFT, ILLEGAL} fun_class_e;

  // Classes occupy contiguous code ranges, so upper-bound compares suffice.
  function automatic fun_class_e fun_class(input logic [3:0] fun);
    if (fun <= ALU_DIV)       return ARITH;
    else if (fun <= ALU_XNOR) return LOGIC;
    else if (fun <= ALU_LT)   return CMP;
    else if (fun <= ALU_SHL)  return SHIFT;
    else                      return ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_flag_check.sv
// alu_flag_check: combinational consistency check of the ALU class flags.
//   fun                      : function code that produced the result
//   flag_arith/logic/cmp/shift: class flags reported by the ALU
//   mismatch                 : 1 when the flags are not exactly the one-hot
//                              pattern of fun's class (never for ILLEGAL)
module alu_flag_check
  import alu_pkg::*;
(
  input  logic [3:0] fun,
  input  logic       flag_arith,
  input  logic       flag_logic,
  input  logic       flag_cmp,
  input  logic       flag_shift,
  output logic       mismatch
);

  fun_class_e cls;
  logic [3:0] expected;
  logic [3:0] flags;

  assign cls   = fun_class(fun);
  assign flags = {flag_arith, flag_logic, flag_cmp, flag_shift};

  always_comb begin
    // NOTE: default first so every path assigns expected and no latch is inferred.
    expected = 4'b0000;
    case (cls)
      ARITH:   expected = 4'b1000;
      LOGIC:   expected = 4'b0100;
      CMP:     expected = 4'b0010;
      SHIFT:   expected = 4'b0001;
      default: expected = 4'b0000;
    endcase
  end

  assign mismatch = (cls != ILLEGAL) && (flags != expected);

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: request/response front end for the synchronous ALU.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/ready     : request handshake; req_a, req_b, req_fun payload
//   alu_a/alu_b/alu_fun : registered drive of the ALU inputs
//   alu_out, alu_*flags : ALU result and flags, captured LAT+1 edges after issue
//   rsp_valid/ready     : response handshake; rsp_data/flags/err payload
//   op_count            : completed responses (wraps)
//   err_count           : error responses (saturates at 255)
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_arith,
  input  logic             alu_logic,
  input  logic             alu_cmp,
  input  logic             alu_shift,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  output logic [15:0]      op_count,
  output logic [7:0]       err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] LAT_CNT = 3'(LAT);

  logic [1:0] state_q;
  logic [2:0] cnt_q;
  logic       rej_q;     // current operation was rejected, ALU result ignored
  logic       is_reject;
  logic       flag_mismatch;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);

  assign is_reject = (req_fun == ALU_NOP) ||
                     ((req_fun == ALU_DIV) && (req_b == '0));

  alu_flag_check u_flag_check (
    .fun        (alu_fun),
    .flag_arith (alu_arith),
    .flag_logic (alu_logic),
    .flag_cmp   (alu_cmp),
    .flag_shift (alu_shift),
    .mismatch   (flag_mismatch)
  );

  // A rejected op spends one WAIT cycle with a zero count so its response
  // appears one cycle after acceptance, without touching the ALU pins.
  // The counter is tested before decrementing, which places the capture
  // LAT+1 edges after acceptance, one edge after ALU_OUT settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rej_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= ALU_NOP;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      op_count  <= '0;
      err_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q <= ST_WAIT;
            if (is_reject) begin
              rej_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              rej_q   <= 1'b0;
              cnt_q   <= LAT_CNT;
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_fun <= req_fun;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            if (rej_q) begin
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
            end else begin
              rsp_data  <= alu_out;
              rsp_flags <= {alu_carry, alu_arith, alu_logic, alu_cmp, alu_shift};
              rsp_err   <= flag_mismatch;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q  <= ST_IDLE;
            op_count <= op_count + 16'd1;
            if (rsp_err && (err_count != 8'hFF))
              err_count <= err_count + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed bench for alu_cmd_issuer. u_dut (LAT=1) drives a
// behavioural ALU; u_dut3 (LAT=3) drives a three-stage ALU model that raises
// the logic flag instead of the arith flag for add.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic [15:0] req_a = '0, req_b = '0;
  logic [3:0]  req_fun = ALU_NOP;
  logic        rsp_ready = 1'b0;

  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] alu_a, alu_b, alu_out, rsp_data, op_count;
  logic [3:0]  alu_fun;
  logic [4:0]  rsp_flags;
  logic [7:0]  err_count;

  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [15:0] alu_a3, alu_b3, alu_out3, rsp_data3, op_count3;
  logic [3:0]  alu_fun3;
  logic [4:0]  rsp_flags3;
  logic [7:0]  err_count3;

  logic [20:0] m1 = '0;                       // {carry,arith,logic,cmp,shift,out}
  logic [20:0] p0 = '0, p1 = '0, p2 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [20:0] alu_eval(input logic [15:0] a, b, input logic [3:0] f);
    logic [16:0] s;
    logic [4:0]  fl;
    logic [15:0] o;
    fl = 5'b0; o = '0;
    case (f)
      ALU_ADD:  begin s = {1'b0, a} + {1'b0, b}; o = s[15:0]; fl = {s[16], 4'b1000}; end
      ALU_SUB:  begin o = a - b; fl = {a < b, 4'b1000}; end
      ALU_MUL:  begin o = 16'(a * b); fl = 5'b01000; end
      ALU_DIV:  begin o = (b != 0) ? a / b : 16'd0; fl = 5'b01000; end
      ALU_AND:  begin o = a & b;    fl = 5'b00100; end
      ALU_OR:   begin o = a | b;    fl = 5'b00100; end
      ALU_NAND: begin o = ~(a & b); fl = 5'b00100; end
      ALU_NOR:  begin o = ~(a | b); fl = 5'b00100; end
      ALU_XOR:  begin o = a ^ b;    fl = 5'b00100; end
      ALU_XNOR: begin o = ~(a ^ b); fl = 5'b00100; end
      ALU_EQ:   begin o = (a == b) ? 16'd1 : 16'd0; fl = 5'b00010; end
      ALU_GT:   begin o = (a > b)  ? 16'd2 : 16'd0; fl = 5'b00010; end
      ALU_LT:   begin o = (a < b)  ? 16'd3 : 16'd0; fl = 5'b00010; end
      ALU_SHR:  begin o = a >> 1; fl = {a[0], 4'b0001}; end
      ALU_SHL:  begin o = a << 1; fl = {a[15], 4'b0001}; end
      default:  begin o = '0; fl = 5'b0; end
    endcase
    return {fl, o};
  endfunction

  always @(posedge clk) m1 <= alu_eval(alu_a, alu_b, alu_fun);

  always @(posedge clk) begin
    logic [20:0] r;
    r = alu_eval(alu_a3, alu_b3, alu_fun3);
    if (alu_fun3 == ALU_ADD) r[19:18] = 2'b01;  // arith dropped, logic raised
    p0 <= r; p1 <= p0; p2 <= p1;
  end

  alu_cmd_issuer #(.WIDTH(16), .LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_out(m1[15:0]),
    .alu_carry(m1[20]), .alu_arith(m1[19]), .alu_logic(m1[18]),
    .alu_cmp(m1[17]), .alu_shift(m1[16]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .op_count(op_count), .err_count(err_count)
  );

  alu_cmd_issuer #(.WIDTH(16), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_fun(alu_fun3), .alu_out(p2[15:0]),
    .alu_carry(p2[20]), .alu_arith(p2[19]), .alu_logic(p2[18]),
    .alu_cmp(p2[17]), .alu_shift(p2[16]),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_data(rsp_data3),
    .rsp_flags(rsp_flags3), .rsp_err(rsp_err3),
    .op_count(op_count3), .err_count(err_count3)
  );

  assign alu_out  = m1[15:0];
  assign alu_out3 = p2[15:0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request and returns #1 after the accepting edge.
  task automatic issue(input bit sel, input logic [15:0] a, b, input logic [3:0] f);
    @(negedge clk);
    req_a = a; req_b = b; req_fun = f;
    if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid3 = 1'b0;
  endtask

  // Counts edges until rsp_valid is seen, bounded to 20.
  task automatic wait_rsp(input bit sel, output int n);
    n = 0;
    while (!(sel ? rsp_valid3 : rsp_valid) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_valid_seen", sel ? rsp_valid3 : rsp_valid, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] a;
    #12 rst = 1'b0;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_alu_fun",   alu_fun, 4'hF);
    check("rst_alu_a",     alu_a, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_counts",    {op_count, err_count}, 0);

    // 1: add 100 + 200
    issue(0, 16'd100, 16'd200, ALU_ADD);
    wait_rsp(0, n);
    check("add_latency", n, 2);
    check("add_data",    rsp_data, 300);
    check("add_flags",   rsp_flags, 5'b01000);
    check("add_err",     rsp_err, 0);
    handshake();
    check("add_op_count", op_count, 1);
    check("add_idle",     req_ready, 1);

    // 2: rejected ops from a fresh reset
    pulse_reset();
    issue(0, 16'd100, 16'd0, ALU_DIV);
    wait_rsp(0, n);
    check("div0_latency", n, 1);
    check("div0_alu_fun", alu_fun, 4'hF);
    check("div0_data",    rsp_data, 0);
    check("div0_flags",   rsp_flags, 0);
    check("div0_err",     rsp_err, 1);
    handshake();
    check("div0_err_count", err_count, 1);
    issue(0, 16'd7, 16'd9, ALU_NOP);
    wait_rsp(0, n);
    check("nop_err", rsp_err, 1);
    handshake();
    check("nop_err_count", err_count, 2);
    check("nop_op_count",  op_count, 2);

    // 3: lt with back-pressure
    issue(0, 16'd5, 16'd50, ALU_LT);
    wait_rsp(0, n);
    check("lt_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      check("lt_hold_data",  rsp_data, 3);
      check("lt_hold_flags", rsp_flags, 5'b00010);
      check("lt_hold_valid", rsp_valid, 1);
      check("lt_req_ready",  req_ready, 0);
      @(posedge clk); #1;
    end
    handshake();
    check("lt_done_valid", rsp_valid, 0);
    check("lt_op_count",   op_count, 3);

    // 4: LAT=3 with a wrong class flag
    issue(1, 16'd1, 16'd1, ALU_ADD);
    wait_rsp(1, n);
    check("lat3_latency", n, 4);
    check("lat3_data",    rsp_data3, 2);
    check("lat3_flags",   rsp_flags3, 5'b00100);
    check("lat3_err",     rsp_err3, 1);
    handshake();
    check("lat3_err_count", err_count3, 1);

    // 5: reset mid-WAIT
    issue(0, 16'h000C, 16'h0003, ALU_XOR);
    rst = 1'b1; #1;
    check("midrst_valid",   rsp_valid, 0);
    check("midrst_ready",   req_ready, 1);
    check("midrst_alu",     {alu_a, alu_b, alu_fun}, {16'd0, 16'd0, 4'hF});
    check("midrst_rsp",     {rsp_data, rsp_flags, rsp_err}, 0);
    check("midrst_counts",  {op_count, err_count}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_rsp",  rsp_valid, 0);
    check("midrst_op_count", op_count, 0);

    // 6: 300 shl ops, then 260 rejections
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 16'(i * 217 + 3);
      issue(0, a, 16'd0, ALU_SHL);
      wait_rsp(0, n);
      check("shl_data", rsp_data, {a[14:0], 1'b0});
      @(posedge clk); #1;
    end
    check("shl_op_count",  op_count, 300);
    check("shl_err_count", err_count, 0);
    for (int i = 0; i < 260; i++) begin
      issue(0, 16'(i), 16'd0, (i % 2 == 0) ? ALU_NOP : ALU_DIV);
      wait_rsp(0, n);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check("sat_err_count", err_count, 8'hFF);
    check("sat_op_count",  op_count, 560);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
